pred_writeback_ctrl: RTL

PRED_WRITEBACK_CTRL -- requirements
Module: pred_writeback_ctrl

---
 rtl/pred_pkg.sv | 33 +++
 rtl/pred_writeback_ctrl_if.sv | 28 ++
 rtl/pred_fifo.sv | 73 +++++++
 rtl/pred_writeback_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/pred_pkg.sv
// Shared types for the predicate write-back controller: address width,
// predicate count, combine operations and the queued entry layout.
package pred_pkg;

   localparam int PRED_ADDR_W = 4;
   localparam int PRED_NUM    = 16;

   typedef enum logic [1:0] {
      OP_WRITE     = 2'b00,
      OP_WRITE_INV = 2'b01,
      OP_AND       = 2'b10,
      OP_OR        = 2'b11
   } pred_op_e;

   typedef struct packed {
      logic [PRED_ADDR_W-1:0] addr;
      logic                   value;
      pred_op_e               op;
   } pred_entry_t;

   // New predicate value from the current register value and the compare outcome.
   function automatic logic pred_apply(pred_op_e op, logic cur, logic val);
      logic r;
      case (op)
         OP_WRITE:     r = val;
         OP_WRITE_INV: r = ~val;
         OP_AND:       r = cur & val;
         default:      r = cur | val;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pred_writeback_ctrl_if.sv
// Compare-result handshake plus predicate register-file port.
// master = producer/register-file side, slave = write-back controller.
interface pred_writeback_ctrl_if;
   import pred_pkg::*;

   logic                   cmp_valid;
   logic                   cmp_ready;
   logic [PRED_ADDR_W-1:0] cmp_addr;
   logic                   cmp_value;
   pred_op_e               cmp_op;

   logic [PRED_ADDR_W-1:0] prf_read_addr;
   logic                   prf_data_out;
   logic                   prf_write_enable;
   logic [PRED_ADDR_W-1:0] prf_write_addr;
   logic                   prf_data_in;

   modport master (
      output cmp_valid, cmp_addr, cmp_value, cmp_op, prf_data_out,
      input  cmp_ready, prf_read_addr, prf_write_enable, prf_write_addr, prf_data_in
   );

   modport slave (
      input  cmp_valid, cmp_addr, cmp_value, cmp_op, prf_data_out,
      output cmp_ready, prf_read_addr, prf_write_enable, prf_write_addr, prf_data_in
   );

endinterface

// File: rtl/pred_fifo.sv
// In-order FIFO of pred_entry_t. Power-of-two DEPTH, pointers wrap naturally,
// separate occupancy count 0..DEPTH. Exposes every slot and its valid bit so
// the owner can build per-address summaries.
module pred_fifo
   import pred_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    flush,
   input  pred_entry_t             push_data,
   output pred_entry_t             head,
   output logic                    full,
   output logic                    empty,
   output pred_entry_t [DEPTH-1:0] slots,
   output logic [DEPTH-1:0]        slot_vld
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0]           wr_ptr, rd_ptr;
   logic [CW-1:0]           count;
   pred_entry_t [DEPTH-1:0] mem;
   logic                    do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign head    = mem[rd_ptr];
   assign slots   = mem;

   // Pointer and count update; flush empties the queue in one edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are only meaningful under slot_vld, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // A slot is live when its distance from the read pointer is below count.
   always_comb begin
      logic [PW-1:0] off;
      slot_vld = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off         = PW'(i) - rd_ptr;
         slot_vld[i] = (CW'(off) < count);
      end
   end

endmodule

// File: rtl/pred_writeback_ctrl.sv
// Predicate write-back controller: queues compare results and retires one per
// cycle into the predicate register file, applying WRITE/WRITE_INV/AND/OR
// against the register's current value.
// Optional build macro: PRED_WB_BYPASS_EN -- an empty queue writes the
// incoming result in the same cycle instead of enqueuing it.
module pred_writeback_ctrl
   import pred_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int NUM_PRED = PRED_NUM
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   pred_writeback_ctrl_if.slave  bus,
   output logic [NUM_PRED-1:0]   pending,
   output logic                  busy
);

   pred_entry_t             in_entry, head;
   pred_entry_t [DEPTH-1:0] slots;
   logic [DEPTH-1:0]        slot_vld;
   logic                    full, empty, push, pop, bypass, ready;
   logic                    we, wdata;
   logic [PRED_ADDR_W-1:0]  waddr, raddr;

   assign in_entry = '{addr: bus.cmp_addr, value: bus.cmp_value, op: bus.cmp_op};

   // A slot freed by this cycle's retire is not reusable until next cycle.
   assign ready = ~full & ~flush;

`ifdef PRED_WB_BYPASS_EN
   assign bypass = empty & ~flush & bus.cmp_valid & ~reset;
`else
   assign bypass = 1'b0;
`endif

   assign push = bus.cmp_valid & ready & ~bypass;
   assign pop  = ~empty & ~flush;
   assign busy = ~empty;

   pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .push_data (in_entry),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .slots     (slots),
      .slot_vld  (slot_vld)
   );

   // Retire path: head entry (or bypassed input) read-modify-written this cycle.
   always_comb begin
      we    = 1'b0;
      waddr = '0;
      raddr = '0;
      wdata = 1'b0;
      if (!empty) begin
         raddr = head.addr;
         if (!flush && !reset) begin
            we    = 1'b1;
            waddr = head.addr;
            wdata = pred_apply(head.op, bus.prf_data_out, head.value);
         end
      end else if (bypass) begin
         raddr = bus.cmp_addr;
         we    = 1'b1;
         waddr = bus.cmp_addr;
         wdata = pred_apply(bus.cmp_op, bus.prf_data_out, bus.cmp_value);
      end
   end

   assign bus.cmp_ready        = ready;
   assign bus.prf_read_addr    = raddr;
   assign bus.prf_write_enable = we;
   assign bus.prf_write_addr   = waddr;
   assign bus.prf_data_in      = wdata;

   // Per-predicate in-flight mask over every live queue slot.
   always_comb begin
      pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int p = 0; p < NUM_PRED; p++) begin
            if (slot_vld[i] && slots[i].addr == PRED_ADDR_W'(p)) pending[p] = 1'b1;
         end
      end
   end

endmodule
